// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and defaults for the SRAM arbiter
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - two-way round-robin grant with last-owner register
module sram_rr_arb
  import sram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last,
  output logic       next_last
);

  always_comb begin
    gnt       = 2'b00;
    next_last = last;
    if (en) begin
      // On a tie the requester that did not own the bus last time wins.
      if (req == 2'b11) gnt = (last == OWN_IF) ? 2'b10 : 2'b01;
      else              gnt = req;
      if (|req) next_last = gnt[OWN_MEM];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) last <= OWN_IF;
    else       last <= next_last;
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one 16-bit async SRAM between fetch and memory stage
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int ADDR_W      = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [15:0]       ram_data,
  output logic              ram_wre_n,
  output logic              ram_oe_n,
  output logic              ram_ce_n,
  output logic              busy
);

  localparam int P  = WAIT_CYCLES + 1;
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] LAST_CNT = CW'(P - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              own, rw;
  logic [ADDR_W-1:1] base;
  logic [31:0]       wdata;
  logic [15:0]       lo_buf;
  logic [1:0]        gnt;
  logic              arb_last, arb_next_last;
  logic              phase_end, in_phase;
  logic              unused_bits;

  sram_rr_arb u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       ({mem_req, if_req}),
    .en        (state == IDLE),
    .gnt       (gnt),
    .last      (arb_last),
    .next_last (arb_next_last)
  );

  assign phase_end = (cnt == LAST_CNT);
  assign in_phase  = (state == LO) || (state == HI);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|gnt)     state_n = LO;
      LO:      if (phase_end) state_n = HI;
      HI:      if (phase_end) state_n = DONE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      own       <= OWN_IF;
      rw        <= 1'b0;
      base      <= '0;
      wdata     <= '0;
      lo_buf    <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_n;
      if (in_phase && !phase_end) cnt <= cnt + 1'b1;
      else                        cnt <= '0;

      if (state == IDLE && |gnt) begin
        own   <= gnt[OWN_MEM];
        rw    <= gnt[OWN_MEM] & mem_rw;
        base  <= gnt[OWN_MEM] ? mem_addr[ADDR_W-1:1] : if_addr[ADDR_W-1:1];
        wdata <= mem_wdata;
      end

      // Async SRAM data is only trusted at the end of the full wait period.
      if (state == LO && phase_end && !rw) lo_buf <= ram_data;
      if (state == HI && phase_end && !rw) begin
        if (own == OWN_MEM) mem_rdata <= {ram_data, lo_buf};
        else                if_rdata  <= {ram_data, lo_buf};
      end
    end
  end

  assign ram_ce_n  = !in_phase;
  assign ram_oe_n  = !(in_phase && !rw);
  assign ram_wre_n = !(in_phase && rw && !phase_end);
  assign ram_addr  = in_phase ? {base, state == HI} : '0;
  assign ram_data  = (in_phase && rw) ? ((state == HI) ? wdata[31:16] : wdata[15:0]) : 16'bz;

  assign if_ack  = (state == DONE) && (own == OWN_IF);
  assign mem_ack = (state == DONE) && (own == OWN_MEM);
  assign busy    = (state != IDLE);

  assign unused_bits = ^{if_addr[0], mem_addr[0], arb_last, arb_next_last};

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int P = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_rw;
  logic [17:0] if_addr, mem_addr;
  logic [31:0] mem_wdata;
  logic        if_ack, mem_ack, ram_wre_n, ram_oe_n, ram_ce_n, busy;
  logic [31:0] if_rdata, mem_rdata;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;

  logic        b_if_req, b_mem_req, b_mem_rw;
  logic [17:0] b_if_addr, b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic        b_if_ack, b_mem_ack, b_ram_wre_n, b_ram_oe_n, b_ram_ce_n, b_busy;
  logic [31:0] b_if_rdata, b_mem_rdata;
  logic [17:0] b_ram_addr;
  wire  [15:0] b_ram_data;

  always #5 clock = ~clock;

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wre_n(ram_wre_n),
    .ram_oe_n(ram_oe_n), .ram_ce_n(ram_ce_n), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(3), .ADDR_W(18)) dut_slow (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .mem_req(b_mem_req), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .ram_addr(b_ram_addr), .ram_data(b_ram_data), .ram_wre_n(b_ram_wre_n),
    .ram_oe_n(b_ram_oe_n), .ram_ce_n(b_ram_ce_n), .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transaction scheduled by cycle offsets from its grant.
  logic [15:0] sram   [0:262143];
  logic [15:0] golden [0:262143];
  int          cyc = 0;
  int          m_start = 0;
  bit          m_active = 0, m_own = 0, m_rw = 0, m_last = 0, chk_on = 0;
  logic [17:0] m_base = '0;
  logic [31:0] m_wdata = '0, exp_if_rdata = '0, exp_mem_rdata = '0;

  always @(posedge clock) begin
    int ended;
    ended = cyc;
    cyc++;
    if (reset) begin
      m_active = 0; m_last = 0; exp_if_rdata = '0; exp_mem_rdata = '0;
    end else if (m_active) begin
      if (m_rw && ended == m_start + P) golden[m_base] = m_wdata[15:0];
      if (ended == m_start + 2*P) begin
        if (m_rw)       golden[m_base + 18'd1] = m_wdata[31:16];
        else if (m_own) exp_mem_rdata = {golden[m_base + 18'd1], golden[m_base]};
        else            exp_if_rdata  = {golden[m_base + 18'd1], golden[m_base]};
      end
      if (ended == m_start + 2*P + 1) m_active = 0;
    end else if (if_req || mem_req) begin
      m_own    = (if_req && mem_req) ? !m_last : mem_req;
      m_last   = m_own;
      m_active = 1;
      m_start  = ended;
      m_rw     = m_own ? mem_rw : 1'b0;
      m_base   = m_own ? {mem_addr[17:1], 1'b0} : {if_addr[17:1], 1'b0};
      m_wdata  = mem_wdata;
    end
  end

  always @(negedge clock) begin
    int k;
    bit lo, hi, done;
    if (chk_on) begin
      k    = cyc - m_start;
      lo   = m_active && k >= 1 && k <= P;
      hi   = m_active && k > P && k <= 2*P;
      done = m_active && k == 2*P + 1;
      chk("busy", busy, m_active);
      chk("ram_ce_n", ram_ce_n, !(lo || hi));
      chk("ram_oe_n", ram_oe_n, !((lo || hi) && !m_rw));
      chk("ram_wre_n", ram_wre_n, !((lo || hi) && m_rw && k != P && k != 2*P));
      chk("if_ack", if_ack, done && !m_own);
      chk("mem_ack", mem_ack, done && m_own);
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("mem_rdata", mem_rdata, exp_mem_rdata);
      if (lo || hi) chk("ram_addr", ram_addr, hi ? m_base + 18'd1 : m_base);
      if ((lo || hi) && m_rw) chk("ram_data", ram_data, hi ? m_wdata[31:16] : m_wdata[15:0]);
    end
  end

  // SRAM pins: read data is garbage until the last cycle of each phase.
  logic [15:0] sram_q = '0;
  bit          sram_en = 0;
  assign ram_data = sram_en ? sram_q : 16'bz;

  always @(negedge clock) begin
    int k;
    k = cyc - m_start;
    sram_en = !ram_ce_n && !ram_oe_n;
    sram_q  = (m_active && (k == P || k == 2*P)) ? sram[ram_addr] : 16'h5A5A;
  end

  always @(posedge clock) if (!ram_ce_n && !ram_wre_n) sram[ram_addr] = ram_data;

  logic [15:0] b_q = '0;
  bit          b_en = 0;
  int          b_cnt = 0;
  assign b_ram_data = b_en ? b_q : 16'bz;

  always @(posedge clock) b_cnt = !b_ram_oe_n ? b_cnt + 1 : 0;
  always @(negedge clock) begin
    b_en = !b_ram_ce_n && !b_ram_oe_n;
    b_q  = (b_cnt % 4 == 3) ? (b_ram_addr[0] ? 16'h7777 : 16'h3333) : 16'hA5A5;
  end

  int oe_lo = 0, wre_lo = 0, b_oe_lo = 0;
  always @(negedge clock) begin
    if (!ram_oe_n)   oe_lo++;
    if (!ram_wre_n)  wre_lo++;
    if (!b_ram_oe_n) b_oe_lo++;
  end

  task automatic txn(input bit own, input bit rw, input logic [17:0] addr, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    @(posedge clock); #2;
    if (own) begin mem_req = 1; mem_rw = rw; mem_addr = addr; mem_wdata = wd; end
    else     begin if_req = 1; if_addr = addr; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (own ? mem_ack : if_ack) begin
        lat = n;
        rd  = own ? mem_rdata : if_rdata;
        break;
      end
    end
    if (own) mem_req = 0; else if_req = 0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL txn_timeout: got no ack expected ack within 40 cycles (owner %0d)", own);
    end
  endtask

  int          lat_a, lat_b, got, last_n, acks;
  logic [31:0] rd_a, rd_b;
  logic [3:0]  order;

  initial begin
    reset = 1; if_req = 0; mem_req = 0; mem_rw = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 0; b_mem_req = 0; b_mem_rw = 0; b_if_addr = '0; b_mem_addr = '0; b_mem_wdata = '0;
    for (int i = 0; i < 262144; i++) begin sram[i] = 16'h0; golden[i] = 16'h0; end
    sram[18'h10] = 16'hBEEF; golden[18'h10] = 16'hBEEF;
    sram[18'h11] = 16'h1234; golden[18'h11] = 16'h1234;
    repeat (3) @(posedge clock);
    #2 reset = 0; chk_on = 1;

    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acks", {if_ack, mem_ack}, 2'b00);
    chk("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
    chk("rst_ram_addr", ram_addr, 18'h0);
    chk("rst_ram_ctl", {ram_ce_n, ram_oe_n, ram_wre_n}, 3'b111);

    oe_lo = 0;
    txn(0, 0, 18'h00010, 32'h0, lat_a, rd_a);
    chk("t1_latency", lat_a, 5);
    chk("t1_rdata", rd_a, 32'h1234BEEF);
    chk("t1_oe_cycles", oe_lo, 4);

    wre_lo = 0;
    txn(1, 1, 18'h00021, 32'hCAFED00D, lat_a, rd_a);
    chk("t2_latency", lat_a, 5);
    chk("t2_wre_cycles", wre_lo, 2);
    chk("t2_sram_lo", sram[18'h20], 16'hD00D);
    chk("t2_sram_hi", sram[18'h21], 16'hCAFE);
    txn(1, 0, 18'h00021, 32'h0, lat_a, rd_a);
    chk("t2_readback", rd_a, 32'hCAFED00D);

    txn(1, 1, 18'h3FFFF, 32'h89AB4567, lat_a, rd_a);
    chk("wrap_sram_lo", sram[18'h3FFFE], 16'h4567);
    chk("wrap_sram_hi", sram[18'h3FFFF], 16'h89AB);
    txn(0, 0, 18'h3FFFE, 32'h0, lat_a, rd_a);
    chk("wrap_readback", rd_a, 32'h89AB4567);

    @(posedge clock); #2 reset = 1;
    @(posedge clock); #2 reset = 0;
    fork
      txn(1, 0, 18'h00010, 32'h0, lat_a, rd_a);
      txn(0, 0, 18'h00020, 32'h0, lat_b, rd_b);
    join
    chk("t3_mem_latency", lat_a, 5);
    chk("t3_if_latency", lat_b, 11);
    chk("t3_mem_rdata", rd_a, 32'h1234BEEF);
    chk("t3_if_rdata", rd_b, 32'hCAFED00D);

    @(posedge clock); #2;
    if_req = 1; if_addr = 18'h10; mem_req = 1; mem_rw = 0; mem_addr = 18'h20;
    order = '0; got = 0; last_n = -1;
    for (int n = 0; n < 60 && got < 4; n++) begin
      @(negedge clock);
      if (mem_ack || if_ack) begin
        order = {order[2:0], mem_ack};
        got++;
        last_n = n;
      end
      if (got == 4) begin if_req = 0; mem_req = 0; end
    end
    if_req = 0; mem_req = 0;
    chk("t4_grant_order", order, 4'b1010);
    chk("t4_fourth_ack_cycle", last_n, 23);

    @(posedge clock); #2;
    mem_req = 1; mem_rw = 1; mem_addr = 18'h40; mem_wdata = 32'h11112222;
    repeat (4) @(negedge clock);
    reset = 1; mem_req = 0;
    @(negedge clock);
    reset = 0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_ram_ctl", {ram_ce_n, ram_wre_n}, 2'b11);
    chk("t5_partial_lo", sram[18'h40], 16'h2222);
    acks = 0;
    repeat (6) begin @(negedge clock); if (mem_ack) acks++; end
    chk("t5_no_mem_ack", acks, 0);
    txn(0, 0, 18'h00011, 32'h0, lat_a, rd_a);
    chk("t5_read_after_reset", rd_a, 32'h1234BEEF);

    @(posedge clock); #2;
    b_if_req = 1; b_if_addr = 18'h51; b_oe_lo = 0; lat_a = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (b_if_ack) begin lat_a = n; rd_a = b_if_rdata; break; end
    end
    b_if_req = 0;
    chk("t6_latency", lat_a, 9);
    chk("t6_rdata", rd_a, 32'h77773333);
    chk("t6_oe_cycles", b_oe_lo, 8);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
